bus_request_unit: RTL and testbench

- Per-core request-side agent sitting directly upstream of the two-core snooping bus controller; one instance per core.
- Turns L1 misses and writes to Shared lines into MSI bus transactions (BusRd/BusUpgr/BusRdX) and drives req_core and the bus operation/address.
- Holds the op until granted, waits a fixed response latency, then returns a fill (data + new MSI state) to L1.
- Drives the core stall used by the arbiter's toggle logic.

---
 rtl/bus_pkg.sv | 35 +++
 rtl/bus_op_decode.sv | 27 ++
 rtl/bus_request_unit.sv | 162 ++++++++++++++++
 tb/tb_bus_request_unit.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types for the per-core bus request agent.
//   bus_op_t    : MSI bus transaction codes driven onto the snooping bus
//   msi_t       : L1 line states
//   req_state_t : request agent FSM states
package bus_pkg;

  typedef enum logic [1:0] {
    BUS_RD   = 2'b00,
    BUS_UPGR = 2'b01,
    BUS_RDX  = 2'b10,
    BUS_NONE = 2'b11
  } bus_op_t;

  typedef enum logic [1:0] {
    MSI_I = 2'b00,
    MSI_S = 2'b01,
    MSI_M = 2'b10
  } msi_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    XFER = 2'b10,
    FILL = 2'b11
  } req_state_t;

  localparam int          LAT_CNT_W  = 4;
  localparam logic [15:0] STARVE_SAT = 16'hFFFF;

  // A plain read leaves the line Shared; both ownership ops leave it Modified.
  function automatic msi_t fill_state_for(input bus_op_t op);
    return (op == BUS_RD) ? MSI_S : MSI_M;
  endfunction

endpackage

// File: rtl/bus_op_decode.sv
// Combinational MSI request decode: maps an L1 access (store flag + current
// line state) to the bus transaction it needs.
// Ports:
//   we         : access is a store
//   line_state : current MSI state of the addressed line
//   op         : bus op to issue (BUS_NONE on a hit)
//   needs_bus  : a bus transaction is required
module bus_op_decode
  import bus_pkg::*;
(
  input  logic    we,
  input  msi_t    line_state,
  output bus_op_t op,
  output logic    needs_bus
);

  always_comb begin
    op = BUS_NONE;
    case (line_state)
      MSI_I:   op = we ? BUS_RDX : BUS_RD;
      MSI_S:   op = we ? BUS_UPGR : BUS_NONE;
      default: op = BUS_NONE;  // M hits, and the unused 2'b11 encoding
    endcase
    needs_bus = (op != BUS_NONE);
  end

endmodule

// File: rtl/bus_request_unit.sv
// Per-core request agent upstream of the two-core snooping bus controller.
// Converts L1 misses / stores to Shared lines into BusRd, BusUpgr or BusRdX,
// holds the op on the bus until granted and through the response latency,
// then returns a one-cycle fill (data + new MSI state) to L1.
//
// Optional feature macro: BUS_REQ_STARVE_CNT_EN adds starve_cnt/starve_max.
//
// Ports:
//   clk, reset (async, active-low)
//   cpu_req_valid/we/addr, l1_line_state : L1 access and line state
//   flush                                : pipeline flush (aborts before grant)
//   grant                                : arbiter grant for this core
//   bus_data_in, cache_hit_in            : bus response
//   req_core, bus_operation_out, bus_address_out : bus request side
//   stall                                : core stall
//   fill_valid/addr/data/state/from_peer : L1 fill
//   starve_cnt, starve_max               : (macro only) grant-wait statistics
//
// state | meaning
// IDLE  | no transaction; decode the L1 access, accept if a bus op is needed
// REQ   | requesting the bus, waiting for grant (flush may abort)
// XFER  | granted; counting down the response latency, op held for snoop
// FILL  | one-cycle fill strobe to L1
module bus_request_unit
  import bus_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int RESP_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req_valid,
  input  logic              cpu_req_we,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [1:0]        l1_line_state,
  input  logic              flush,
  input  logic              grant,
  input  logic [DATA_W-1:0] bus_data_in,
  input  logic              cache_hit_in,
  output logic              req_core,
  output logic [1:0]        bus_operation_out,
  output logic [ADDR_W-1:0] bus_address_out,
  output logic              stall,
  output logic              fill_valid,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [DATA_W-1:0] fill_data,
  output logic [1:0]        fill_state,
  output logic              fill_from_peer
`ifdef BUS_REQ_STARVE_CNT_EN
  ,
  output logic [15:0]       starve_cnt,
  output logic [15:0]       starve_max
`endif
);

  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(RESP_LAT - 1);

  req_state_t            state_q, state_d;
  bus_op_t               dec_op, op_q;
  logic                  dec_needs;
  logic                  accept;
  logic [ADDR_W-1:0]     addr_q;
  logic [LAT_CNT_W-1:0]  lat_cnt_q;
  logic                  xfer_done;

  bus_op_decode u_decode (
    .we         (cpu_req_we),
    .line_state (msi_t'(l1_line_state)),
    .op         (dec_op),
    .needs_bus  (dec_needs)
  );

  assign accept    = (state_q == IDLE) && cpu_req_valid && dec_needs && !flush;
  assign xfer_done = (state_q == XFER) && (lat_cnt_q == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = REQ;
      // grant wins over a same-cycle flush: once granted the op must complete
      REQ:  if (grant) state_d = XFER;
            else if (flush) state_d = IDLE;
      XFER: if (lat_cnt_q == '0) state_d = FILL;
      FILL: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_core          = 1'b0;
    bus_operation_out = BUS_NONE;
    stall             = 1'b0;
    fill_valid        = 1'b0;
    case (state_q)
      IDLE: stall = accept;
      REQ, XFER: begin
        req_core          = 1'b1;
        bus_operation_out = op_q;
        stall             = 1'b1;
      end
      FILL: begin
        fill_valid = 1'b1;
        stall      = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus_address_out = addr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q           <= BUS_NONE;
      addr_q         <= '0;
      lat_cnt_q      <= '0;
      fill_addr      <= '0;
      fill_data      <= '0;
      fill_state     <= MSI_I;
      fill_from_peer <= 1'b0;
    end else begin
      if (accept) begin
        op_q   <= dec_op;
        addr_q <= cpu_req_addr;
      end
      if ((state_q == REQ) && grant)
        lat_cnt_q <= LAT_LOAD;
      else if ((state_q == XFER) && (lat_cnt_q != '0))
        lat_cnt_q <= lat_cnt_q - 1'b1;
      if (xfer_done) begin
        fill_addr      <= addr_q;
        fill_state     <= fill_state_for(op_q);
        fill_from_peer <= cache_hit_in;
        // an upgrade already holds the data; the bus returns nothing useful
        if (op_q != BUS_UPGR) fill_data <= bus_data_in;
      end
    end
  end

`ifdef BUS_REQ_STARVE_CNT_EN
  logic [15:0] starve_nxt;
  assign starve_nxt = starve_cnt + 16'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
      starve_max <= '0;
    end else if (accept) begin
      starve_cnt <= '0;
    end else if ((state_q == REQ) && !grant && (starve_cnt != STARVE_SAT)) begin
      starve_cnt <= starve_nxt;
      if (starve_nxt > starve_max) starve_max <= starve_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_bus_request_unit.sv
module tb_bus_request_unit;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int RESP_LAT = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              cpu_req_valid, cpu_req_we;
  logic [ADDR_W-1:0] cpu_req_addr;
  logic [1:0]        l1_line_state;
  logic              flush, grant;
  logic [DATA_W-1:0] bus_data_in;
  logic              cache_hit_in;
  logic              req_core;
  logic [1:0]        bus_operation_out;
  logic [ADDR_W-1:0] bus_address_out;
  logic              stall, fill_valid;
  logic [ADDR_W-1:0] fill_addr;
  logic [DATA_W-1:0] fill_data;
  logic [1:0]        fill_state;
  logic              fill_from_peer;
`ifdef BUS_REQ_STARVE_CNT_EN
  logic [15:0]       starve_cnt, starve_max;
`endif

  always #5 clk = ~clk;

  bus_request_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESP_LAT(RESP_LAT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req_valid(cpu_req_valid), .cpu_req_we(cpu_req_we),
    .cpu_req_addr(cpu_req_addr), .l1_line_state(l1_line_state),
    .flush(flush), .grant(grant), .bus_data_in(bus_data_in),
    .cache_hit_in(cache_hit_in), .req_core(req_core),
    .bus_operation_out(bus_operation_out), .bus_address_out(bus_address_out),
    .stall(stall), .fill_valid(fill_valid), .fill_addr(fill_addr),
    .fill_data(fill_data), .fill_state(fill_state), .fill_from_peer(fill_from_peer)
`ifdef BUS_REQ_STARVE_CNT_EN
    , .starve_cnt(starve_cnt), .starve_max(starve_max)
`endif
  );

  int n_cmp  = 0;
  int n_fail = 0;
  logic [DATA_W-1:0] m_fill_data;    // last data actually delivered to L1
  logic [15:0]       m_starve_max;

  // MSI request rules: I-load -> BusRd, I-store -> BusRdX, S-store -> BusUpgr
  function automatic logic [1:0] model_op(input logic we, input logic [1:0] st);
    if (st == 2'b00) return we ? 2'b10 : 2'b00;
    if (st == 2'b01 && we) return 2'b01;
    return 2'b11;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One transaction on the timeline: accept, gdelay ungranted REQ cycles,
  // grant cycle, RESP_LAT transfer cycles, fill. Ends on the cycle after FILL.
  task automatic run_txn(input logic we, input logic [1:0] st, input logic [31:0] addr,
                         input int gdelay, input logic [31:0] fdata, input bit flush_late);
    logic [1:0]  op;
    logic        h;
    logic [36:0] obs, exp;
    op = model_op(we, st);
    cpu_req_valid = 1'b1; cpu_req_we = we; cpu_req_addr = addr; l1_line_state = st;
    flush = 1'b0; grant = 1'b0; h = 1'b0;
    #1;
    n_cmp++;
    if (stall !== (op != 2'b11) || req_core !== 1'b0 || fill_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL accept: stall=%b req=%b fv=%b required stall=%b req=0 fv=0",
               stall, req_core, fill_valid, op != 2'b11);
    end
    next_cycle();
    if (op == 2'b11) begin
      cpu_req_valid = 1'b0;
      #1;
      n_cmp++;
      if ({req_core, bus_operation_out, stall, fill_valid} !== 5'b0_11_0_0) begin
        n_fail++;
        $display("FAIL hit_no_bus: req/op/stall/fv=%b required 0_11_0_0",
                 {req_core, bus_operation_out, stall, fill_valid});
      end
      next_cycle();
      return;
    end
    for (int i = 0; i <= gdelay; i++) begin
      // the stalled core keeps presenting something; it must be ignored
      cpu_req_we = 1'($urandom); cpu_req_addr = $urandom; l1_line_state = 2'($urandom_range(0, 2));
      grant = (i == gdelay);
      flush = (i == gdelay) ? flush_late : 1'b0;
      #1;
      obs = {req_core, bus_operation_out, stall, fill_valid, bus_address_out};
      exp = {1'b1, op, 1'b1, 1'b0, addr};
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL req_phase cyc%0d: got %h required %h", i, obs, exp);
      end
`ifdef BUS_REQ_STARVE_CNT_EN
      if (i == gdelay) begin
        if (16'(gdelay) > m_starve_max) m_starve_max = 16'(gdelay);
        n_cmp++;
        if (starve_cnt !== 16'(gdelay) || starve_max !== m_starve_max) begin
          n_fail++;
          $display("FAIL starve: cnt=%0d max=%0d required cnt=%0d max=%0d",
                   starve_cnt, starve_max, gdelay, m_starve_max);
        end
      end
`endif
      next_cycle();
    end
    for (int i = 0; i < RESP_LAT; i++) begin
      grant = 1'($urandom);   // deassertion during transfer is ignored
      flush = flush_late;
      bus_data_in = (i == RESP_LAT - 1) ? fdata : $urandom;
      cache_hit_in = 1'($urandom);
      h = cache_hit_in;
      #1;
      obs = {req_core, bus_operation_out, stall, fill_valid, bus_address_out};
      exp = {1'b1, op, 1'b1, 1'b0, addr};
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL xfer_phase cyc%0d: got %h required %h", i, obs, exp);
      end
      next_cycle();
    end
    cpu_req_valid = 1'b0; grant = 1'b0; flush = 1'b0;
    if (op != 2'b01) m_fill_data = fdata;
    #1;
    n_cmp++;
    if ({req_core, bus_operation_out, stall, fill_valid} !== 5'b0_11_1_1) begin
      n_fail++;
      $display("FAIL fill_ctrl: req/op/stall/fv=%b required 0_11_1_1",
               {req_core, bus_operation_out, stall, fill_valid});
    end
    n_cmp++;
    if (fill_addr !== addr || fill_data !== m_fill_data ||
        fill_state !== ((op == 2'b00) ? 2'b01 : 2'b10) || fill_from_peer !== h) begin
      n_fail++;
      $display("FAIL fill_data: addr=%h data=%h st=%b peer=%b required addr=%h data=%h st=%b peer=%b",
               fill_addr, fill_data, fill_state, fill_from_peer, addr, m_fill_data,
               (op == 2'b00) ? 2'b01 : 2'b10, h);
    end
    next_cycle();
  endtask

  task automatic idle_check(input string name);
    cpu_req_valid = 1'b0; grant = 1'b0; flush = 1'b0;
    #1;
    n_cmp++;
    if ({req_core, bus_operation_out, stall, fill_valid} !== 5'b0_11_0_0) begin
      n_fail++;
      $display("FAIL %s: req/op/stall/fv=%b required 0_11_0_0", name,
               {req_core, bus_operation_out, stall, fill_valid});
    end
    next_cycle();
  endtask

  task automatic check_reset_outputs(input string name);
    n_cmp++;
    if ({req_core, bus_operation_out, stall, fill_valid, fill_state, fill_from_peer} !== 8'b0_11_0_0_00_0 ||
        bus_address_out !== '0 || fill_addr !== '0 || fill_data !== '0) begin
      n_fail++;
      $display("FAIL %s: req=%b op=%b stall=%b fv=%b fst=%b peer=%b baddr=%h faddr=%h fdata=%h required all zero, op=11",
               name, req_core, bus_operation_out, stall, fill_valid, fill_state,
               fill_from_peer, bus_address_out, fill_addr, fill_data);
    end
`ifdef BUS_REQ_STARVE_CNT_EN
    n_cmp++;
    if (starve_cnt !== 16'd0 || starve_max !== 16'd0) begin
      n_fail++;
      $display("FAIL %s_starve: cnt=%0d max=%0d required 0 0", name, starve_cnt, starve_max);
    end
`endif
  endtask

  task automatic test_reset();
    reset = 1'b0; cpu_req_valid = 1'b0; cpu_req_we = 1'b0; cpu_req_addr = '0;
    l1_line_state = 2'b00; flush = 1'b0; grant = 1'b0; bus_data_in = '0; cache_hit_in = 1'b0;
    m_fill_data = '0; m_starve_max = '0;
    @(negedge clk); @(negedge clk);
    #1;
    check_reset_outputs("reset_state");
    @(negedge clk);
    reset = 1'b1;
    next_cycle();
  endtask

  task automatic test_directed();
    run_txn(1'b0, 2'b00, 32'h100, 0, 32'hDEADBEEF, 1'b0);  // BusRd
    idle_check("after_busrd");
    run_txn(1'b1, 2'b01, 32'h200, 0, 32'h12345678, 1'b0);  // BusUpgr keeps data
    run_txn(1'b1, 2'b00, 32'h300, 5, 32'hCAFEF00D, 1'b0);  // BusRdX starved 5
    run_txn(1'b0, 2'b10, 32'h400, 0, 32'h0, 1'b0);         // M hit
    run_txn(1'b1, 2'b10, 32'h404, 0, 32'h0, 1'b0);         // store M hit
    run_txn(1'b0, 2'b01, 32'h408, 0, 32'h0, 1'b0);         // load S hit
    idle_check("after_hits");
  endtask

  task automatic test_flush();
    cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = 32'h500; l1_line_state = 2'b00;
    flush = 1'b1;
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle_block: stall=%b required 0", stall);
    end
    next_cycle();
    idle_check("flush_idle_noreq");
    cpu_req_valid = 1'b1; cpu_req_we = 1'b1; cpu_req_addr = 32'h600; l1_line_state = 2'b00;
    next_cycle();
    cpu_req_valid = 1'b0;
    next_cycle();
    flush = 1'b1; grant = 1'b0;
    #1;
    n_cmp++;
    if (req_core !== 1'b1 || bus_operation_out !== 2'b10) begin
      n_fail++;
      $display("FAIL flush_req_hold: req=%b op=%b required 1 10", req_core, bus_operation_out);
    end
    next_cycle();
`ifdef BUS_REQ_STARVE_CNT_EN
    if (m_starve_max < 16'd2) m_starve_max = 16'd2;
`endif
    for (int i = 0; i < RESP_LAT + 3; i++) idle_check("flush_abort_nofill");
    run_txn(1'b0, 2'b00, 32'h700, 2, 32'hA5A5A5A5, 1'b1);  // flush after grant: completes
  endtask

  task automatic test_back_to_back();
    run_txn(1'b1, 2'b00, 32'h800, 0, 32'h11111111, 1'b0);
    run_txn(1'b0, 2'b00, 32'h804, 1, 32'h22222222, 1'b0);
    run_txn(1'b1, 2'b01, 32'h808, 0, 32'h33333333, 1'b0);
    idle_check("b2b_end");
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      run_txn(1'($urandom), 2'($urandom_range(0, 2)), $urandom, int'($urandom_range(0, 6)),
              $urandom, 1'($urandom));
      if ($urandom_range(0, 1) == 1) idle_check("rand_idle");
    end
  endtask

  task automatic test_reset_mid();
    cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = 32'h900; l1_line_state = 2'b00;
    next_cycle();
    cpu_req_valid = 1'b0; grant = 1'b1;
    next_cycle();
    grant = 1'b0; bus_data_in = 32'hBADBAD00; cache_hit_in = 1'b1;
    #1;
    reset = 1'b0;
    m_fill_data = '0; m_starve_max = '0;
    #1;
    check_reset_outputs("reset_mid_xfer");
    @(negedge clk);
    reset = 1'b1;
    next_cycle();
    for (int i = 0; i < RESP_LAT + 3; i++) idle_check("after_reset_nofill");
    run_txn(1'b0, 2'b00, 32'hA00, 0, 32'h0BADF00D, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_flush();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
